// File: rtl/ps2_key_event_ctrl_if.sv
// ----------------------------------------------------------------------------
// ps2_key_event_ctrl_if
// Consumer-side key event bus of ps2_key_event_ctrl.
//   evt_valid  : event FIFO non-empty
//   evt_data   : head event {brk, ext, code[7:0]}
//   evt_ack    : pop the head (ignored while evt_valid=0)
//   evt_count  : entries queued, PTR_W+1 bits
//   overflow   : sticky, an event was dropped on a full FIFO
//   clear_ovf  : clears overflow
// master = controller side, slave = consumer side.
// PTR_W must match the PTR_W of the controller it is attached to.
// ----------------------------------------------------------------------------
interface ps2_key_event_ctrl_if #(
    parameter int PTR_W = 2
);
    logic             evt_valid;
    logic [9:0]       evt_data;
    logic             evt_ack;
    logic [PTR_W:0]   evt_count;
    logic             overflow;
    logic             clear_ovf;

    modport master (
        output evt_valid, evt_data, evt_count, overflow,
        input  evt_ack, clear_ovf
    );

    modport slave (
        input  evt_valid, evt_data, evt_count, overflow,
        output evt_ack, clear_ovf
    );
endinterface

// File: rtl/ps2_key_event_ctrl.sv
// ----------------------------------------------------------------------------
// ps2_key_event_ctrl
// Parses the PS/2 scan-code byte stream (E0 extended, F0 break, E1 pause),
// keeps held-level arrow outputs and queues key events in a show-ahead FIFO.
//   clock, resetn    : system clock, synchronous active-low reset
//   ps2_key_pressed  : one-cycle strobe qualifying ps2_key_data
//   ps2_key_data     : received scan-code byte
//   left/right/up/down : arrow key currently held (extended codes only)
//   evt_if (master)  : event FIFO bus, see ps2_key_event_ctrl_if
// Optional: define PS2_TYPEMATIC_FILTER_EN to suppress repeated identical
// makes (keyboard auto-repeat) from the FIFO.
// ----------------------------------------------------------------------------
module ps2_key_event_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                ps2_key_pressed,
    input  logic [7:0]          ps2_key_data,
    output logic                left,
    output logic                right,
    output logic                up,
    output logic                down,
    ps2_key_event_ctrl_if.master evt_if
);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK, ST_SKIP
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       skip_cnt_q, skip_cnt_d;
    logic             emit, emit_brk, emit_ext;
    logic             push;
    logic [9:0]       evt_word;
    logic [3:0]       arrow_q, arrow_d;      // {left, right, up, down}
    logic [9:0]       mem_q [FIFO_DEPTH];
    logic [9:0]       mem_d [FIFO_DEPTH];
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    logic             ovf_q, ovf_d;
    logic             full, empty, pop, push_ok;

    // Bytes the keyboard sends that are not key codes (BAT, ACK, resend, errors)
    function automatic logic is_dropped(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
               (b == 8'h00) || (b == 8'hFF);
    endfunction

    // ---- parser FSM: state register ----
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            skip_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    // ---- parser FSM: next state ----
    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        if (ps2_key_pressed) begin
            case (state_q)
                ST_IDLE: begin
                    if (ps2_key_data == 8'hE0)      state_d = ST_EXT;
                    else if (ps2_key_data == 8'hF0) state_d = ST_BRK;
                    else if (ps2_key_data == 8'hE1) begin
                        state_d    = ST_SKIP;
                        skip_cnt_d = 3'd7;           // rest of the 8-byte pause make
                    end
                end
                ST_EXT:     state_d = (ps2_key_data == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
                ST_BRK,
                ST_EXT_BRK: state_d = ST_IDLE;
                ST_SKIP: begin
                    skip_cnt_d = skip_cnt_q - 3'd1;
                    if (skip_cnt_q <= 3'd1) state_d = ST_IDLE;
                end
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // ---- parser FSM: event outputs ----
    always_comb begin
        emit     = 1'b0;
        emit_brk = 1'b0;
        emit_ext = 1'b0;
        if (ps2_key_pressed) begin
            case (state_q)
                ST_IDLE:    emit = !(ps2_key_data == 8'hE0 || ps2_key_data == 8'hF0 ||
                                     ps2_key_data == 8'hE1 || is_dropped(ps2_key_data));
                ST_EXT: begin
                    emit     = (ps2_key_data != 8'hF0);
                    emit_ext = 1'b1;
                end
                ST_BRK: begin
                    emit     = 1'b1;
                    emit_brk = 1'b1;
                end
                ST_EXT_BRK: begin
                    emit     = 1'b1;
                    emit_brk = 1'b1;
                    emit_ext = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign evt_word = {emit_brk, emit_ext, ps2_key_data};

`ifdef PS2_TYPEMATIC_FILTER_EN
    // ---- typematic filter: last forwarded make ----
    logic       last_vld_q, last_vld_d;
    logic [8:0] last_make_q, last_make_d;
    logic       repeat_hit;

    always_comb begin
        last_vld_d  = last_vld_q;
        last_make_d = last_make_q;
        repeat_hit  = emit && !emit_brk && last_vld_q &&
                      (last_make_q == {emit_ext, ps2_key_data});
        if (emit) begin
            if (emit_brk) begin
                last_vld_d = 1'b0;
            end else begin
                last_vld_d  = 1'b1;
                last_make_d = {emit_ext, ps2_key_data};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            last_vld_q  <= 1'b0;
            last_make_q <= '0;
        end else begin
            last_vld_q  <= last_vld_d;
            last_make_q <= last_make_d;
        end
    end

    assign push = emit && !repeat_hit;
`else
    assign push = emit;
`endif

    // ---- arrow levels: extended codes only, independent of FIFO state ----
    always_comb begin
        arrow_d = arrow_q;
        if (emit && emit_ext) begin
            case (ps2_key_data)
                8'h6B:   arrow_d[3] = !emit_brk;
                8'h74:   arrow_d[2] = !emit_brk;
                8'h75:   arrow_d[1] = !emit_brk;
                8'h72:   arrow_d[0] = !emit_brk;
                default: ;
            endcase
        end
    end

    // ---- event FIFO: pointers carry one extra bit so full != empty ----
    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        empty    = (count == '0);
        full     = (count == CNT_W'(FIFO_DEPTH));
        pop      = evt_if.evt_ack && !empty;
        push_ok  = push && (!full || pop);
        wr_ptr_d = push_ok ? wr_ptr_q + CNT_W'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + CNT_W'(1) : rd_ptr_q;
        mem_d    = mem_q;
        if (push_ok) mem_d[wr_ptr_q[PTR_W-1:0]] = evt_word;
        ovf_d = ovf_q;
        if (evt_if.clear_ovf)               ovf_d = 1'b0;
        else if (push && full && !pop)      ovf_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            arrow_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            arrow_q  <= arrow_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; the head is masked to zero while empty instead.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign {left, right, up, down} = arrow_q;
    assign evt_if.evt_valid = !empty;
    assign evt_if.evt_data  = empty ? 10'd0 : mem_q[rd_ptr_q[PTR_W-1:0]];
    assign evt_if.evt_count = count;
    assign evt_if.overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ps2_key_event_ctrl
// Directed vector table, a hand-written arrow hold sequence, and randomized
// byte streams compared against a flag/queue reference model.
// ----------------------------------------------------------------------------
module tb_ps2_key_event_ctrl;
    localparam int DEPTH = 4;
    localparam int PW    = 2;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       stb = 1'b0;
    logic [7:0] kd = 8'h00;
    logic       left, right, up, down;

    ps2_key_event_ctrl_if #(.PTR_W(PW)) evt_if();

    ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .PTR_W(PW)) dut (
        .clock           (clock),
        .resetn          (resetn),
        .ps2_key_pressed (stb),
        .ps2_key_data    (kd),
        .left            (left),
        .right           (right),
        .up              (up),
        .down            (down),
        .evt_if          (evt_if)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // expected/observed packing: {arrows[3:0], vld, data[9:0], cnt[2:0], ovf}
    typedef struct {
        bit         rstn;
        bit         s;
        logic [7:0] d;
        bit         ack;
        bit         clr;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit rstn, input bit s, input logic [7:0] d,
                                input bit ack, input bit clr, input logic [3:0] arr,
                                input bit vld, input logic [9:0] data,
                                input logic [2:0] cnt, input bit ovf);
        vec_t v;
        v.rstn = rstn; v.s = s; v.d = d; v.ack = ack; v.clr = clr;
        v.exp  = {arr, vld, data, cnt, ovf};
        vecs.push_back(v);
    endfunction

    function automatic logic [18:0] observed();
        return {left, right, up, down, evt_if.evt_valid, evt_if.evt_data,
                evt_if.evt_count, evt_if.overflow};
    endfunction

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got arr=%b vld=%b data=%h cnt=%0d ovf=%b, want arr=%b vld=%b data=%h cnt=%0d ovf=%b",
                     name, act[18:15], act[14], act[13:4], act[3:1], act[0],
                     exp[18:15], exp[14], exp[13:4], exp[3:1], exp[0]);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, return on the falling edge.
    task automatic step(input bit rstn, input bit s, input logic [7:0] d,
                        input bit ack, input bit clr);
        resetn = rstn; stb = s; kd = d;
        evt_if.evt_ack = ack; evt_if.clear_ovf = clr;
        @(posedge clock);
        @(negedge clock);
        stb = 1'b0; evt_if.evt_ack = 1'b0; evt_if.clear_ovf = 1'b0;
    endtask

    // ---------------- reference model ----------------
    bit          m_ext, m_brk;
    int          m_skip;
    bit [3:0]    m_arr;
    logic [9:0]  m_q[$];
    bit          m_ovf;
`ifdef PS2_TYPEMATIC_FILTER_EN
    bit          m_lv;
    logic [8:0]  m_lm;
`endif

    task automatic model_cycle(input bit rstn, input bit s, input logic [7:0] d,
                               input bit ack, input bit clr);
        bit         have;
        bit         full;
        bit         popped;
        logic [9:0] ev;
        if (!rstn) begin
            m_ext = 0; m_brk = 0; m_skip = 0; m_arr = '0; m_q.delete(); m_ovf = 0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            m_lv = 0; m_lm = '0;
`endif
            return;
        end
        have = 0;
        ev   = '0;
        if (s) begin
            if (m_skip > 0) m_skip--;
            else if (!m_ext && !m_brk) begin
                if (d == 8'hE0) m_ext = 1;
                else if (d == 8'hF0) m_brk = 1;
                else if (d == 8'hE1) m_skip = 7;
                else if (!(d inside {8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF})) begin
                    have = 1; ev = {2'b00, d};
                end
            end else if (!m_brk) begin
                if (d == 8'hF0) m_brk = 1;
                else begin have = 1; ev = {2'b01, d}; m_ext = 0; end
            end else begin
                have = 1; ev = {1'b1, m_ext, d}; m_ext = 0; m_brk = 0;
            end
        end
        if (have && ev[8]) begin
            case (ev[7:0])
                8'h6B:   m_arr[3] = !ev[9];
                8'h74:   m_arr[2] = !ev[9];
                8'h75:   m_arr[1] = !ev[9];
                8'h72:   m_arr[0] = !ev[9];
                default: ;
            endcase
        end
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (have) begin
            if (ev[9]) m_lv = 0;
            else if (m_lv && m_lm == ev[8:0]) have = 0;
            else begin m_lv = 1; m_lm = ev[8:0]; end
        end
`endif
        full   = (m_q.size() == DEPTH);
        popped = ack && (m_q.size() > 0);
        if (popped) void'(m_q.pop_front());
        if (have) begin
            if (!full || popped) m_q.push_back(ev);
            else m_ovf = 1;
        end
        if (clr) m_ovf = 0;
    endtask

    function automatic logic [18:0] model_exp();
        logic [9:0] head;
        logic [2:0] cnt;
        head = (m_q.size() > 0) ? m_q[0] : 10'd0;
        cnt  = 3'(m_q.size());
        return {m_arr, (m_q.size() > 0), head, cnt, m_ovf};
    endfunction

    function automatic logic [7:0] rand_byte();
        logic [7:0] pool [12];
        pool = '{8'hE0, 8'hF0, 8'hE1, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h1C,
                 8'hAA, 8'h00, 8'hFF, 8'h29};
        if ($urandom_range(0, 3) == 0) return 8'($urandom);
        return pool[$urandom_range(0, 11)];
    endfunction

    initial begin
        logic [7:0] pause_seq [8];
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        evt_if.evt_ack = 1'b0;
        evt_if.clear_ovf = 1'b0;

        // ---- vector table ----
        add(0,0,8'h00,0,0, 4'b0000,0,10'h000,0,0);
        // extended up make/break
        add(1,1,8'hE0,0,0, 4'b0000,0,10'h000,0,0);
        add(1,1,8'h75,0,0, 4'b0010,1,10'h175,1,0);
        add(1,1,8'hE0,0,0, 4'b0010,1,10'h175,1,0);
        add(1,1,8'hF0,0,0, 4'b0010,1,10'h175,1,0);
        add(1,1,8'h75,0,0, 4'b0000,1,10'h175,2,0);
        add(1,0,8'h00,1,0, 4'b0000,1,10'h375,1,0);
        add(1,0,8'h00,1,0, 4'b0000,0,10'h000,0,0);
        // plain make/break
        add(1,1,8'h1C,0,0, 4'b0000,1,10'h01C,1,0);
        add(1,1,8'hF0,0,0, 4'b0000,1,10'h01C,1,0);
        add(1,1,8'h1C,0,0, 4'b0000,1,10'h01C,2,0);
        add(1,0,8'h00,1,0, 4'b0000,1,10'h21C,1,0);
        add(1,0,8'h00,1,0, 4'b0000,0,10'h000,0,0);
        // keypad 6B vs extended left
        add(1,1,8'h6B,0,0, 4'b0000,1,10'h06B,1,0);
        add(1,1,8'hE0,0,0, 4'b0000,1,10'h06B,1,0);
        add(1,1,8'h6B,0,0, 4'b1000,1,10'h06B,2,0);
        add(1,0,8'h00,1,0, 4'b1000,1,10'h16B,1,0);
        add(1,0,8'h00,1,0, 4'b1000,0,10'h000,0,0);
        add(1,1,8'hE0,0,0, 4'b1000,0,10'h000,0,0);
        add(1,1,8'hF0,0,0, 4'b1000,0,10'h000,0,0);
        add(1,1,8'h6B,0,0, 4'b0000,1,10'h36B,1,0);
        add(1,0,8'h00,1,0, 4'b0000,0,10'h000,0,0);
        // pause sequence produces nothing, then 29
        for (int i = 0; i < 8; i++) add(1,1,pause_seq[i],0,0, 4'b0000,0,10'h000,0,0);
        add(1,1,8'h29,0,0, 4'b0000,1,10'h029,1,0);
        add(1,0,8'h00,1,0, 4'b0000,0,10'h000,0,0);
        // overflow, full push with pop, clear
        add(1,1,8'h15,0,0, 4'b0000,1,10'h015,1,0);
        add(1,1,8'h16,0,0, 4'b0000,1,10'h015,2,0);
        add(1,1,8'h1A,0,0, 4'b0000,1,10'h015,3,0);
        add(1,1,8'h1B,0,0, 4'b0000,1,10'h015,4,0);
        add(1,1,8'h1D,0,0, 4'b0000,1,10'h015,4,1);
        add(1,1,8'h21,1,0, 4'b0000,1,10'h016,4,1);
        add(1,0,8'h00,0,1, 4'b0000,1,10'h016,4,0);
        add(1,0,8'h00,1,0, 4'b0000,1,10'h01A,3,0);
        add(1,0,8'h00,1,0, 4'b0000,1,10'h01B,2,0);
        add(1,0,8'h00,1,0, 4'b0000,1,10'h021,1,0);
        add(1,0,8'h00,1,0, 4'b0000,0,10'h000,0,0);
        // push and ack together while empty
        add(1,1,8'h22,1,0, 4'b0000,1,10'h022,1,0);
        add(1,0,8'h00,1,0, 4'b0000,0,10'h000,0,0);
        // clear_ovf beats a simultaneous overflow; reset beats a strobe
        add(1,1,8'h23,0,0, 4'b0000,1,10'h023,1,0);
        add(1,1,8'h24,0,0, 4'b0000,1,10'h023,2,0);
        add(1,1,8'h25,0,0, 4'b0000,1,10'h023,3,0);
        add(1,1,8'h26,0,0, 4'b0000,1,10'h023,4,0);
        add(1,1,8'h2A,0,1, 4'b0000,1,10'h023,4,0);
        add(1,1,8'h2B,0,0, 4'b0000,1,10'h023,4,1);
        add(0,1,8'h2C,0,0, 4'b0000,0,10'h000,0,0);
        // reset during a pending E0
        add(1,1,8'hE0,0,0, 4'b0000,0,10'h000,0,0);
        add(0,0,8'h00,0,0, 4'b0000,0,10'h000,0,0);
        add(1,1,8'h75,0,0, 4'b0000,1,10'h075,1,0);
        add(1,0,8'h00,1,0, 4'b0000,0,10'h000,0,0);
        // arrows still update while the FIFO is full
        add(1,1,8'h31,0,0, 4'b0000,1,10'h031,1,0);
        add(1,1,8'h32,0,0, 4'b0000,1,10'h031,2,0);
        add(1,1,8'h33,0,0, 4'b0000,1,10'h031,3,0);
        add(1,1,8'h34,0,0, 4'b0000,1,10'h031,4,0);
        add(1,1,8'hE0,0,0, 4'b0000,1,10'h031,4,0);
        add(1,1,8'h74,0,0, 4'b0100,1,10'h031,4,1);
        add(0,0,8'h00,0,0, 4'b0000,0,10'h000,0,0);
        // auto-repeat
`ifdef PS2_TYPEMATIC_FILTER_EN
        add(1,1,8'h1C,0,0, 4'b0000,1,10'h01C,1,0);
        add(1,1,8'h1C,0,0, 4'b0000,1,10'h01C,1,0);
        add(1,1,8'h1C,0,0, 4'b0000,1,10'h01C,1,0);
        add(1,0,8'h00,1,0, 4'b0000,0,10'h000,0,0);
        add(1,0,8'h00,1,0, 4'b0000,0,10'h000,0,0);
        add(1,0,8'h00,1,0, 4'b0000,0,10'h000,0,0);
`else
        add(1,1,8'h1C,0,0, 4'b0000,1,10'h01C,1,0);
        add(1,1,8'h1C,0,0, 4'b0000,1,10'h01C,2,0);
        add(1,1,8'h1C,0,0, 4'b0000,1,10'h01C,3,0);
        add(1,0,8'h00,1,0, 4'b0000,1,10'h01C,2,0);
        add(1,0,8'h00,1,0, 4'b0000,1,10'h01C,1,0);
        add(1,0,8'h00,1,0, 4'b0000,0,10'h000,0,0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rstn, vecs[i].s, vecs[i].d, vecs[i].ack, vecs[i].clr);
            check($sformatf("vec%0d", i), observed(), vecs[i].exp);
        end

        // ---- hand-written: down level holds across idle cycles ----
        step(0,0,8'h00,0,0);
        step(1,1,8'hE0,0,0);
        step(1,1,8'h72,0,0);
        check("down_set", observed(), {4'b0001, 1'b1, 10'h172, 3'd1, 1'b0});
        for (int i = 0; i < 3; i++) begin
            step(1,0,8'h00,0,0);
            check($sformatf("down_hold%0d", i), observed(), {4'b0001, 1'b1, 10'h172, 3'd1, 1'b0});
        end
        step(1,1,8'hE0,0,0);
        step(1,1,8'hF0,0,0);
        step(1,1,8'h72,0,0);
        check("down_clr", observed(), {4'b0000, 1'b1, 10'h172, 3'd2, 1'b0});
        step(1,0,8'h00,1,0);
        check("down_pop1", observed(), {4'b0000, 1'b1, 10'h372, 3'd1, 1'b0});
        step(1,0,8'h00,1,0);
        check("down_pop2", observed(), {4'b0000, 1'b0, 10'h000, 3'd0, 1'b0});

        // ---- randomized stream vs reference model ----
        model_cycle(0,0,8'h00,0,0);
        step(0,0,8'h00,0,0);
        check("rand_reset", observed(), model_exp());
        for (int i = 0; i < 3000; i++) begin
            bit         r_rstn, r_s, r_ack, r_clr;
            logic [7:0] r_d;
            r_rstn = ($urandom_range(0, 299) != 0);
            r_s    = ($urandom_range(0, 1) == 1);
            r_d    = rand_byte();
            r_ack  = (((i / 400) % 2) == 0) ? ($urandom_range(0, 9) == 0)
                                            : ($urandom_range(0, 9) < 6);
            r_clr  = ($urandom_range(0, 39) == 0);
            model_cycle(r_rstn, r_s, r_d, r_ack, r_clr);
            step(r_rstn, r_s, r_d, r_ack, r_clr);
            check($sformatf("rand%0d", i), observed(), model_exp());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
